// File: rtl/vec_alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared types and constants for the vector ALU sequencer:
//            ALU opcode encoding, sequencer state encoding, element width
//            and the latched vector-command record.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int ELEM_W     = 32;

    // Field widths of the latched command record. These match the default
    // sequencer configuration (ADDR_W = 8, VLEN_MAX = 64).
    localparam int VEC_ADDR_W = 8;
    localparam int VEC_LEN_W  = 7;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        NOR = 4'd4,
        SL  = 4'd5,
        SR  = 4'd6,
        SLT = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [3:0]            op;
        logic                  sign;
        logic [4:0]            shamt;
        logic [VEC_LEN_W-1:0]  len;
        logic [VEC_ADDR_W-1:0] src_a;
        logic [VEC_ADDR_W-1:0] src_b;
        logic [VEC_ADDR_W-1:0] dst;
    } vec_cmd_t;

endpackage
`default_nettype wire

// File: rtl/vec_alu_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vec_addr_gen
// Purpose  : Element index counters and wrapped RAM addresses for one
//            vector command. The read index advances on every read strobe;
//            the write index is the read index delayed by one read, which
//            lines it up with the RAM's one-cycle read latency.
// Ports    : clk, rst_n       - clock, async active-low reset
//            clear            - restart both indices at 0 (command accept)
//            step             - a read is issued this cycle
//            len              - latched element count
//            src_a/src_b/dst  - latched base addresses
//            rd_addr_a/b      - src + read index (mod 2^ADDR_W)
//            wr_addr          - dst + write index (mod 2^ADDR_W)
//            last             - read index is the final element
// Revision : 1.0 - initial release
// ============================================================================
module vec_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);

    logic [LEN_W-1:0]  r_rd_idx;
    logic [LEN_W-1:0]  r_wr_idx;
    logic [ADDR_W-1:0] w_rd_off;
    logic [ADDR_W-1:0] w_wr_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
        end else if (clear) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
        end else if (step) begin
            r_rd_idx <= r_rd_idx + LEN_W'(1);
            r_wr_idx <= r_rd_idx;
        end
    end

    // Offsets are resized to the address width so base+index wraps naturally.
    assign w_rd_off  = ADDR_W'(r_rd_idx);
    assign w_wr_off  = ADDR_W'(r_wr_idx);

    assign rd_addr_a = src_a + w_rd_off;
    assign rd_addr_b = src_b + w_rd_off;
    assign wr_addr   = dst + w_wr_off;

    // Only meaningful while reading, where len is at least 1.
    assign last      = (r_rd_idx == (len - LEN_W'(1)));

endmodule
`default_nettype wire

// File: rtl/vec_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_alu_sequencer
// Purpose  : Vector command sequencer in front of a 32-bit scalar ALU.
//            Latches one command, streams element pairs from a synchronous
//            two-read-port RAM through the ALU at one element per cycle,
//            writes each result back and accumulates the ALU flags.
// Ports    : cmd_*            - command handshake and fields
//            rd_* / wr_*      - element RAM read and write ports
//            alu_*            - scalar ALU operands, controls and results
//            busy, done       - status, done is a one-cycle pulse
//            flag_*           - flags accumulated over the vector
//            red_sum          - wrapping sum of written results
//                               (only when VSEQ_REDUCE_EN is defined)
// Options  : VSEQ_REDUCE_EN   - adds the red_sum reduction output
// Revision : 1.0 - initial release
// ============================================================================
module vec_alu_sequencer
    import vec_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int VLEN_MAX = 64,
    localparam int LEN_W   = $clog2(VLEN_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic              cmd_sign,
    input  logic [4:0]        cmd_shamt,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ELEM_W-1:0] rd_data_a,
    input  logic [ELEM_W-1:0] rd_data_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ELEM_W-1:0] wr_data,
    output logic [ELEM_W-1:0] alu_a,
    output logic [ELEM_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_op,
    output logic              alu_use_sign,
    input  logic [ELEM_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_cout,
    output logic              busy,
    output logic              done,
    output logic              flag_zero_all,
    output logic              flag_ovf_any,
    output logic              flag_cout_any
`ifdef VSEQ_REDUCE_EN
    ,
    output logic [ELEM_W-1:0] red_sum
`endif
);

    localparam logic [1:0] c_ST_IDLE  = SEQ_IDLE;
    localparam logic [1:0] c_ST_RUN   = SEQ_RUN;
    localparam logic [1:0] c_ST_DRAIN = SEQ_DRAIN;
    localparam logic [1:0] c_ST_DONE  = SEQ_DONE;

    logic [1:0]        r_state;
    vec_cmd_t          r_cmd;
    logic              r_wr_valid;
    logic              r_flag_zero;
    logic              r_flag_ovf;
    logic              r_flag_cout;

    logic              w_accept;
    logic              w_idle;
    logic              w_run;
    logic              w_last;
    logic [LEN_W-1:0]  w_len_clamped;
    logic [ADDR_W-1:0] w_gen_rd_a;
    logic [ADDR_W-1:0] w_gen_rd_b;
    logic [ADDR_W-1:0] w_gen_wr;

    assign w_idle        = (r_state == c_ST_IDLE);
    assign w_run         = (r_state == c_ST_RUN);
    assign w_accept      = cmd_valid && w_idle;
    assign w_len_clamped = (cmd_len > LEN_W'(VLEN_MAX)) ? LEN_W'(VLEN_MAX) : cmd_len;

    // ------------------------------------------------------------------
    // Command FSM and write-stage valid bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cmd      <= '0;
            r_wr_valid <= 1'b0;
        end else begin
            // A read issued this cycle returns data next cycle: write then.
            r_wr_valid <= w_run;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd.op    <= cmd_op;
                        r_cmd.sign  <= cmd_sign;
                        r_cmd.shamt <= cmd_shamt;
                        r_cmd.len   <= VEC_LEN_W'(w_len_clamped);
                        r_cmd.src_a <= VEC_ADDR_W'(cmd_src_a);
                        r_cmd.src_b <= VEC_ADDR_W'(cmd_src_b);
                        r_cmd.dst   <= VEC_ADDR_W'(cmd_dst);
                        r_state     <= (w_len_clamped == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN:   if (w_last) r_state <= c_ST_DRAIN;
                c_ST_DRAIN: r_state <= c_ST_DONE;
                c_ST_DONE:  r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flag accumulation. Accept and write never coincide, since writes
    // only happen while busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_zero <= 1'b1;
            r_flag_ovf  <= 1'b0;
            r_flag_cout <= 1'b0;
        end else if (w_accept) begin
            r_flag_zero <= 1'b1;
            r_flag_ovf  <= 1'b0;
            r_flag_cout <= 1'b0;
        end else if (r_wr_valid) begin
            r_flag_zero <= r_flag_zero & alu_zero;
            r_flag_ovf  <= r_flag_ovf | alu_overflow;
            r_flag_cout <= r_flag_cout | alu_cout;
        end
    end

`ifdef VSEQ_REDUCE_EN
    logic [ELEM_W-1:0] r_red_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red_sum <= '0;
        end else if (w_accept) begin
            r_red_sum <= '0;
        end else if (r_wr_valid) begin
            r_red_sum <= r_red_sum + alu_res;
        end
    end

    assign red_sum = r_red_sum;
`endif

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    vec_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_accept),
        .step      (w_run),
        .len       (LEN_W'(r_cmd.len)),
        .src_a     (ADDR_W'(r_cmd.src_a)),
        .src_b     (ADDR_W'(r_cmd.src_b)),
        .dst       (ADDR_W'(r_cmd.dst)),
        .rd_addr_a (w_gen_rd_a),
        .rd_addr_b (w_gen_rd_b),
        .wr_addr   (w_gen_wr),
        .last      (w_last)
    );

    // ------------------------------------------------------------------
    // Outputs. Addresses read as 0 whenever their strobe is low.
    // ------------------------------------------------------------------
    assign cmd_ready     = w_idle;
    assign busy          = !w_idle;
    assign done          = (r_state == c_ST_DONE);

    assign rd_en         = w_run;
    assign rd_addr_a     = w_run ? w_gen_rd_a : '0;
    assign rd_addr_b     = w_run ? w_gen_rd_b : '0;

    assign wr_en         = r_wr_valid;
    assign wr_addr       = r_wr_valid ? w_gen_wr : '0;
    assign wr_data       = alu_res;

    assign alu_a         = rd_data_a;
    assign alu_b         = rd_data_b;
    assign alu_op        = w_idle ? 4'd0 : r_cmd.op;
    assign alu_use_sign  = w_idle ? 1'b0 : r_cmd.sign;
    assign alu_shamt     = w_idle ? 5'd0 : r_cmd.shamt;

    assign flag_zero_all = r_flag_zero;
    assign flag_ovf_any  = r_flag_ovf;
    assign flag_cout_any = r_flag_cout;

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_alu_sequencer
// Purpose  : Directed self-checking bench for vec_alu_sequencer. Provides a
//            synchronous two-read-port element RAM with a preload port and a
//            behavioural scalar ALU, then walks a fixed list of commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_alu_sequencer;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic              cmd_sign;
    logic [4:0]        cmd_shamt;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [31:0]       rd_data_a, rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [31:0]       alu_a, alu_b;
    logic [4:0]        alu_shamt;
    logic [3:0]        alu_op;
    logic              alu_use_sign;
    logic [31:0]       alu_res;
    logic              alu_zero, alu_overflow, alu_cout;
    logic              busy, done;
    logic              flag_zero_all, flag_ovf_any, flag_cout_any;
`ifdef VSEQ_REDUCE_EN
    logic [31:0]       red_sum;
`endif

    always #5 clk = ~clk;

    vec_alu_sequencer #(.ADDR_W(ADDR_W), .VLEN_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sign(cmd_sign), .cmd_shamt(cmd_shamt),
        .cmd_len(cmd_len), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_op(alu_op), .alu_use_sign(alu_use_sign),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_cout(alu_cout),
        .busy(busy), .done(done),
        .flag_zero_all(flag_zero_all), .flag_ovf_any(flag_ovf_any),
        .flag_cout_any(flag_cout_any)
`ifdef VSEQ_REDUCE_EN
        , .red_sum(red_sum)
`endif
    );

    // ---------------- element RAM (read-old-data on collision) ----------
    logic [31:0]       mem [0:255];
    logic              ld_we;
    logic [7:0]        ld_addr;
    logic [31:0]       ld_data;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
        if (wr_en)      mem[wr_addr] <= wr_data;
        else if (ld_we) mem[ld_addr] <= ld_data;
    end

    // ---------------- behavioural scalar ALU -----------------------------
    always_comb begin
        logic [32:0] s;
        s            = '0;
        alu_res      = '0;
        alu_overflow = 1'b0;
        alu_cout     = 1'b0;
        case (alu_op)
            4'd0: begin
                s            = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res      = s[31:0];
                alu_cout     = s[32];
                alu_overflow = alu_use_sign && (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            4'd1: begin
                alu_res      = alu_a - alu_b;
                alu_cout     = (alu_a < alu_b);
                alu_overflow = alu_use_sign && (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            4'd2: alu_res = alu_a & alu_b;
            4'd3: alu_res = alu_a | alu_b;
            4'd4: alu_res = ~(alu_a | alu_b);
            4'd5: alu_res = alu_a << alu_shamt;
            4'd6: alu_res = alu_use_sign ? 32'($signed(alu_a) >>> alu_shamt) : (alu_a >> alu_shamt);
            4'd7: alu_res = alu_use_sign ? {31'd0, $signed(alu_a) < $signed(alu_b)} : {31'd0, alu_a < alu_b};
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    // ---------------- activity monitor -----------------------------------
    int         rd_cnt  = 0;
    int         wr_cnt  = 0;
    int         acc_cnt = 0;
    logic [7:0] rd_log [0:1023];
    logic [7:0] wr_log [0:1023];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_log[rd_cnt] <= rd_addr_a;
            rd_cnt         <= rd_cnt + 1;
        end
        if (wr_en) begin
            wr_log[wr_cnt] <= wr_addr;
            wr_cnt         <= wr_cnt + 1;
        end
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    // ---------------- checking helpers -----------------------------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    // Presents a command in the current cycle; returns in cycle 1.
    task automatic issue(input logic [3:0] op, input logic sgn, input logic [4:0] sh,
                         input logic [LEN_W-1:0] len, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input bit hold);
        cmd_op    = op;
        cmd_sign  = sgn;
        cmd_shamt = sh;
        cmd_len   = len;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        cmd_valid = 1'b1;
        chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        tick();
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle index in which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------------------------
    int cyc;
    int r0, w0, a0;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_sign  = 1'b0;
        cmd_shamt = '0;
        cmd_len   = '0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_dst   = '0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",  {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_done",   {31'd0, done},      32'd0);
        chk("rst_rd_en",  {31'd0, rd_en},     32'd0);
        chk("rst_wr_en",  {31'd0, wr_en},     32'd0);
        chk("rst_addrs",  {8'd0, rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
        chk("rst_flags",  {29'd0, flag_zero_all, flag_ovf_any, flag_cout_any}, 32'd4);
        chk("rst_alu_op", {28'd0, alu_op},    32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) poke(8'(i), 32'd0);

        // 1: ADD unsigned, len 4
        poke(8'h00, 32'd1);  poke(8'h01, 32'd2);  poke(8'h02, 32'd3);  poke(8'h03, 32'd4);
        poke(8'h20, 32'd10); poke(8'h21, 32'd20); poke(8'h22, 32'd30); poke(8'h23, 32'd40);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(4'd0, 1'b0, 5'd0, 7'd4, 8'h00, 8'h20, 8'h40, 1'b0);
        chk("add_c1_rd_en",  {31'd0, rd_en}, 32'd1);
        chk("add_c1_addr_b", {24'd0, rd_addr_b}, 32'h20);
        wait_done(cyc);
        chk("add_done_cycle", cyc, 32'd6);
        chk("add_flags", {29'd0, flag_zero_all, flag_ovf_any, flag_cout_any}, 32'd0);
        chk("add_rd_count", rd_cnt - r0, 32'd4);
        chk("add_wr_count", wr_cnt - w0, 32'd4);
        chk("add_dst0", mem[8'h40], 32'd11);
        chk("add_dst1", mem[8'h41], 32'd22);
        chk("add_dst2", mem[8'h42], 32'd33);
        chk("add_dst3", mem[8'h43], 32'd44);
        tick();
        chk("add_done_pulse", {31'd0, done}, 32'd0);
        chk("add_ready_after", {31'd0, cmd_ready}, 32'd1);

        // 2: SUB signed, len 2
        poke(8'h50, 32'h8000_0000); poke(8'h51, 32'd5);
        poke(8'h60, 32'd1);         poke(8'h61, 32'd5);
        issue(4'd1, 1'b1, 5'd0, 7'd2, 8'h50, 8'h60, 8'h70, 1'b0);
        chk("sub_alu_op",   {28'd0, alu_op}, 32'd1);
        chk("sub_alu_sign", {31'd0, alu_use_sign}, 32'd1);
        wait_done(cyc);
        chk("sub_done_cycle", cyc, 32'd4);
        chk("sub_flags", {29'd0, flag_zero_all, flag_ovf_any, flag_cout_any}, 32'd2);
        chk("sub_dst0", mem[8'h70], 32'h7FFF_FFFF);
        chk("sub_dst1", mem[8'h71], 32'd0);
        tick();
        chk("sub_idle_alu_op", {28'd0, alu_op}, 32'd0);

        // 3: len 0
        r0 = rd_cnt; w0 = wr_cnt;
        issue(4'd0, 1'b0, 5'd0, 7'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("len0_done_c1", {31'd0, done}, 32'd1);
        chk("len0_zero_all", {31'd0, flag_zero_all}, 32'd1);
        tick();
        chk("len0_ready_c2", {31'd0, cmd_ready}, 32'd1);
        chk("len0_no_rd", rd_cnt - r0, 32'd0);
        chk("len0_no_wr", wr_cnt - w0, 32'd0);

        // 4: address wrap, OR
        poke(8'hFE, 32'd1);     poke(8'hFF, 32'd2);     poke(8'h00, 32'd4);
        poke(8'h10, 32'h100);   poke(8'h11, 32'h200);   poke(8'h12, 32'h400);
        r0 = rd_cnt; w0 = wr_cnt;
        issue(4'd3, 1'b0, 5'd0, 7'd3, 8'hFE, 8'h10, 8'hFF, 1'b0);
        wait_done(cyc);
        chk("wrap_done_cycle", cyc, 32'd5);
        chk("wrap_rd0", {24'd0, rd_log[r0]},     32'hFE);
        chk("wrap_rd1", {24'd0, rd_log[r0 + 1]}, 32'hFF);
        chk("wrap_rd2", {24'd0, rd_log[r0 + 2]}, 32'h00);
        chk("wrap_wr0", {24'd0, wr_log[w0]},     32'hFF);
        chk("wrap_wr1", {24'd0, wr_log[w0 + 1]}, 32'h00);
        chk("wrap_wr2", {24'd0, wr_log[w0 + 2]}, 32'h01);
        chk("wrap_dstFF", mem[8'hFF], 32'h101);
        chk("wrap_dst00", mem[8'h00], 32'h202);
        chk("wrap_dst01", mem[8'h01], 32'h404);
        tick();

        // 5: cmd_valid held through, then back-to-back SL
        poke(8'hA0, 32'hFF00_FF00); poke(8'hA1, 32'h0F0F_0F0F);
        poke(8'hB0, 32'h0FF0_0FF0); poke(8'hB1, 32'hF0F0_F0F0);
        poke(8'hC0, 32'h8000_000F); poke(8'hC8, 32'd0);
        a0 = acc_cnt;
        issue(4'd2, 1'b0, 5'd0, 7'd2, 8'hA0, 8'hB0, 8'hE0, 1'b1);
        wait_done(cyc);
        chk("hold_done_cycle", cyc, 32'd4);
        chk("hold_one_accept", acc_cnt - a0, 32'd1);
        cmd_op = 4'd5; cmd_shamt = 5'd4; cmd_len = 7'd1;
        cmd_src_a = 8'hC0; cmd_src_b = 8'hC8; cmd_dst = 8'hD0;
        tick();
        chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_two_accepts", acc_cnt - a0, 32'd2);
        wait_done(cyc);
        chk("b2b_done_cycle", cyc, 32'd3);
        chk("and_dst0", mem[8'hE0], 32'h0F00_0F00);
        chk("and_dst1", mem[8'hE1], 32'd0);
        chk("sl_dst",   mem[8'hD0], 32'h0000_00F0);
        tick();

        // 7: length clamp, a-a gives all-zero results
        poke(8'hBF, 32'h0000_DEAD);
        w0 = wr_cnt;
        issue(4'd1, 1'b0, 5'd0, 7'd100, 8'h00, 8'h00, 8'h80, 1'b0);
        wait_done(cyc);
        chk("clamp_done_cycle", cyc, 32'd66);
        chk("clamp_wr_count", wr_cnt - w0, 32'd64);
        chk("clamp_flags", {29'd0, flag_zero_all, flag_ovf_any, flag_cout_any}, 32'd4);
        chk("clamp_last", mem[8'hBF], 32'd0);
        chk("clamp_beyond", mem[8'hC0], 32'h8000_000F);
        tick();

        // 6: reset during RUN after two writes
        poke(8'h00, 32'd3); poke(8'h01, 32'd5); poke(8'h02, 32'd7);
        poke(8'h12, 32'h5A5A);
        w0 = wr_cnt;
        issue(4'd0, 1'b0, 5'd0, 7'd8, 8'h00, 8'h00, 8'h10, 1'b0);
        tick();
        tick();
        tick();
        chk("rstrun_wr_before", {31'd0, wr_en}, 32'd1);
        chk("rstrun_zero_before", {31'd0, flag_zero_all}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstrun_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rstrun_busy",  {31'd0, busy},  32'd0);
        chk("rstrun_flags", {29'd0, flag_zero_all, flag_ovf_any, flag_cout_any}, 32'd4);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rstrun_wr_count", wr_cnt - w0, 32'd2);
        chk("rstrun_dst0", mem[8'h10], 32'd6);
        chk("rstrun_dst1", mem[8'h11], 32'd10);
        chk("rstrun_dst2", mem[8'h12], 32'h5A5A);
        chk("rstrun_idle", {31'd0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
